// File: rtl/wb_enc_frontend_pkg.sv
// Shared constants, types and field helpers for the Wishbone front-end of the LWE core.
package wb_enc_frontend_pkg;

  localparam logic [31:0] DEF_OPCODE_ADDR = 32'h3000_0000;
  localparam logic [31:0] DEF_STATUS_ADDR = 32'h3000_0004;
  localparam int unsigned DEF_DATA_WIDTH  = 128;
  localparam int unsigned DEF_ADDR_WIDTH  = 10;

  localparam int unsigned WB_DW = 32;
  localparam int unsigned SEL_W = 4;

  // Instruction word layout: {dst, src1, src0, opcode} packed from bit 0 upward
  localparam int unsigned OPCODE_W   = 2;
  localparam int unsigned OPCODE_LSB = 0;
  localparam int unsigned SRC0_LSB   = OPCODE_LSB + OPCODE_W;

  function automatic int unsigned src1_lsb(input int unsigned aw);
    return SRC0_LSB + aw;
  endfunction

  function automatic int unsigned dst_lsb(input int unsigned aw);
    return SRC0_LSB + 2 * aw;
  endfunction

  // Opcode encodings; the meaning is owned by the core, the front-end only forwards them
  localparam logic [OPCODE_W-1:0] OP_ENC = 2'd0;
  localparam logic [OPCODE_W-1:0] OP_DEC = 2'd1;
  localparam logic [OPCODE_W-1:0] OP_ADD = 2'd2;
  localparam logic [OPCODE_W-1:0] OP_MUL = 2'd3;

  typedef enum logic [1:0] {
    RGN_MEM      = 2'd0,
    RGN_OPC      = 2'd1,
    RGN_STAT     = 2'd2,
    RGN_UNMAPPED = 2'd3
  } region_e;

  localparam int unsigned STATE_W = 3;
  localparam logic [STATE_W-1:0] S_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] S_RD_WAIT = 3'd1;
  localparam logic [STATE_W-1:0] S_RD_CAP  = 3'd2;
  localparam logic [STATE_W-1:0] S_RMW_WR  = 3'd3;
  localparam logic [STATE_W-1:0] S_ISSUE   = 3'd4;
  localparam logic [STATE_W-1:0] S_ACK     = 3'd5;

endpackage

// File: rtl/wb_enc_frontend_addr_decode.sv
// Combinational Wishbone address classifier and instruction-field extractor.
module wb_addr_decode
  import wb_enc_frontend_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter logic [31:0] OPCODE_ADDR = DEF_OPCODE_ADDR,
  parameter logic [31:0] STATUS_ADDR = DEF_STATUS_ADDR
) (
  input  logic [WB_DW-1:0]      adr,
  input  logic [WB_DW-1:0]      dat,
  output region_e               region_c,
  output logic [ADDR_WIDTH-1:0] word_c,
  output logic [OPCODE_W-1:0]   opcode_c,
  output logic [ADDR_WIDTH-1:0] src0_c,
  output logic [ADDR_WIDTH-1:0] src1_c,
  output logic [ADDR_WIDTH-1:0] dst_c
);

  localparam int unsigned SRC1_LSB = src1_lsb(ADDR_WIDTH);
  localparam int unsigned DST_LSB  = dst_lsb(ADDR_WIDTH);

  assign word_c   = adr[ADDR_WIDTH-1:0];
  assign opcode_c = dat[OPCODE_LSB +: OPCODE_W];
  assign src0_c   = dat[SRC0_LSB +: ADDR_WIDTH];
  assign src1_c   = dat[SRC1_LSB +: ADDR_WIDTH];
  assign dst_c    = dat[DST_LSB +: ADDR_WIDTH];

  // Scratchpad window sits at the bottom of the address space
  always_comb begin
    region_c = RGN_UNMAPPED;
    if (adr[WB_DW-1:ADDR_WIDTH] == '0) begin
      region_c = RGN_MEM;
    end else if (adr == OPCODE_ADDR) begin
      region_c = RGN_OPC;
    end else if (adr == STATUS_ADDR) begin
      region_c = RGN_STAT;
    end
  end

endmodule

// File: rtl/wb_enc_frontend.sv
// Wishbone slave front-end: scratchpad access with byte-merge, instruction issue and status readback.
module wb_enc_frontend
  import wb_enc_frontend_pkg::*;
#(
  parameter logic [31:0] OPCODE_ADDR = DEF_OPCODE_ADDR,
  parameter logic [31:0] STATUS_ADDR = DEF_STATUS_ADDR,
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [SEL_W-1:0]      wbs_sel_i,
  input  logic [WB_DW-1:0]      wbs_dat_i,
  input  logic [WB_DW-1:0]      wbs_adr_i,
  output logic                  wbs_ack_o,
  output logic [WB_DW-1:0]      wbs_dat_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  core_busy_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [OPCODE_W-1:0]   instr_opcode_o,
  output logic [ADDR_WIDTH-1:0] instr_src0_o,
  output logic [ADDR_WIDTH-1:0] instr_src1_o,
  output logic [ADDR_WIDTH-1:0] instr_dst_o
);

  region_e               region_c;
  logic [ADDR_WIDTH-1:0] word_c;
  logic [OPCODE_W-1:0]   opcode_c;
  logic [ADDR_WIDTH-1:0] src0_c;
  logic [ADDR_WIDTH-1:0] src1_c;
  logic [ADDR_WIDTH-1:0] dst_c;

  wb_addr_decode #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .OPCODE_ADDR (OPCODE_ADDR),
    .STATUS_ADDR (STATUS_ADDR)
  ) u_decode (
    .adr      (wbs_adr_i),
    .dat      (wbs_dat_i),
    .region_c (region_c),
    .word_c   (word_c),
    .opcode_c (opcode_c),
    .src0_c   (src0_c),
    .src1_c   (src1_c),
    .dst_c    (dst_c)
  );

  logic [STATE_W-1:0]    state_q,  state_d;
  logic                  ack_q,    ack_d;
  logic [WB_DW-1:0]      dat_q,    dat_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  valid_q,  valid_d;
  logic [OPCODE_W-1:0]   opcode_q, opcode_d;
  logic [ADDR_WIDTH-1:0] src0_q,   src0_d;
  logic [ADDR_WIDTH-1:0] src1_q,   src1_d;
  logic [ADDR_WIDTH-1:0] dst_q,    dst_d;
  logic [WB_DW-1:0]      wdat_q,   wdat_d;
  logic [SEL_W-1:0]      sel_q,    sel_d;
  logic                  rmw_q,    rmw_d;
  logic                  drop_q,   drop_d;

  logic                  req_c;
  logic                  ack_ok_c;
  logic [DATA_WIDTH-1:0] merged_c;

  assign req_c    = wbs_cyc_i & wbs_stb_i;
  // A master that let go of cyc at any point before the ack must not see one
  assign ack_ok_c = wbs_cyc_i & ~drop_q;

  // Byte-lane merge of the held write data into the word just read back
  always_comb begin
    merged_c = mem_rdata_i;
    for (int b = 0; b < int'(SEL_W); b++) begin
      if (sel_q[b]) merged_c[8*b +: 8] = wdat_q[8*b +: 8];
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    ack_d       = 1'b0;
    dat_d       = '0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    valid_d     = valid_q;
    opcode_d    = opcode_q;
    src0_d      = src0_q;
    src1_d      = src1_q;
    dst_d       = dst_q;
    wdat_d      = wdat_q;
    sel_d       = sel_q;
    rmw_d       = rmw_q;
    drop_d      = drop_q | ~wbs_cyc_i;

    case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        if (req_c) begin
          case (region_c)
            RGN_MEM: begin
              if (!core_busy_i) begin
                mem_addr_d = word_c;
                mem_en_d   = 1'b1;
                if (wbs_we_i && wbs_sel_i == {SEL_W{1'b1}}) begin
                  mem_we_d    = 1'b1;
                  mem_wdata_d = DATA_WIDTH'(wbs_dat_i);
                  ack_d       = 1'b1;
                  state_d     = S_ACK;
                end else begin
                  rmw_d   = wbs_we_i;
                  wdat_d  = wbs_dat_i;
                  sel_d   = wbs_sel_i;
                  state_d = S_RD_WAIT;
                end
              end
            end
            RGN_OPC: begin
              if (wbs_we_i) begin
                opcode_d = opcode_c;
                src0_d   = src0_c;
                src1_d   = src1_c;
                dst_d    = dst_c;
                valid_d  = 1'b1;
                state_d  = S_ISSUE;
              end else begin
                ack_d   = 1'b1;
                state_d = S_ACK;
              end
            end
            RGN_STAT: begin
              if (!wbs_we_i) dat_d = {30'd0, valid_q, core_busy_i};
              ack_d   = 1'b1;
              state_d = S_ACK;
            end
            default: begin
              ack_d   = 1'b1;
              state_d = S_ACK;
            end
          endcase
        end
      end
      S_RD_WAIT: begin
        state_d = S_RD_CAP;
      end
      S_RD_CAP: begin
        if (rmw_q) begin
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_wdata_d = merged_c;
          state_d     = S_RMW_WR;
        end else begin
          dat_d   = mem_rdata_i[WB_DW-1:0];
          ack_d   = ack_ok_c;
          state_d = S_ACK;
        end
      end
      S_RMW_WR: begin
        ack_d   = ack_ok_c;
        state_d = S_ACK;
      end
      S_ISSUE: begin
        if (instr_ready_i) begin
          valid_d = 1'b0;
          ack_d   = ack_ok_c;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered-output flops
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      ack_q       <= 1'b0;
      dat_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      valid_q     <= 1'b0;
      opcode_q    <= '0;
      src0_q      <= '0;
      src1_q      <= '0;
      dst_q       <= '0;
      wdat_q      <= '0;
      sel_q       <= '0;
      rmw_q       <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      valid_q     <= valid_d;
      opcode_q    <= opcode_d;
      src0_q      <= src0_d;
      src1_q      <= src1_d;
      dst_q       <= dst_d;
      wdat_q      <= wdat_d;
      sel_q       <= sel_d;
      rmw_q       <= rmw_d;
      drop_q      <= drop_d;
    end
  end

  assign wbs_ack_o      = ack_q;
  assign wbs_dat_o      = dat_q;
  assign mem_en_o       = mem_en_q;
  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign instr_valid_o  = valid_q;
  assign instr_opcode_o = opcode_q;
  assign instr_src0_o   = src0_q;
  assign instr_src1_o   = src1_q;
  assign instr_dst_o    = dst_q;

endmodule

// File: tb/tb_wb_enc_frontend.sv
// Scoreboard bench for wb_enc_frontend: stimulus pushes expected acks, memory pulses and instructions.
module tb_wb_enc_frontend;
  import wb_enc_frontend_pkg::*;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i;
  logic          wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]    wbs_sel_i;
  logic [31:0]   wbs_dat_i, wbs_adr_i;
  logic          wbs_ack_o;
  logic [31:0]   wbs_dat_o;
  logic          mem_en_o, mem_we_o;
  logic [9:0]    mem_addr_o;
  logic [127:0]  mem_wdata_o;
  logic [127:0]  mem_rdata_i;
  logic          core_busy_i;
  logic          instr_valid_o, instr_ready_i;
  logic [1:0]    instr_opcode_o;
  logic [9:0]    instr_src0_o, instr_src1_o, instr_dst_o;

  wb_enc_frontend dut (
    .wb_clk_i       (wb_clk_i),
    .wb_rst_i       (wb_rst_i),
    .wbs_stb_i      (wbs_stb_i),
    .wbs_cyc_i      (wbs_cyc_i),
    .wbs_we_i       (wbs_we_i),
    .wbs_sel_i      (wbs_sel_i),
    .wbs_dat_i      (wbs_dat_i),
    .wbs_adr_i      (wbs_adr_i),
    .wbs_ack_o      (wbs_ack_o),
    .wbs_dat_o      (wbs_dat_o),
    .mem_en_o       (mem_en_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rdata_i    (mem_rdata_i),
    .core_busy_i    (core_busy_i),
    .instr_valid_o  (instr_valid_o),
    .instr_ready_i  (instr_ready_i),
    .instr_opcode_o (instr_opcode_o),
    .instr_src0_o   (instr_src0_o),
    .instr_src1_o   (instr_src1_o),
    .instr_dst_o    (instr_dst_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int cnt = 0;
  always @(posedge wb_clk_i) cnt <= cnt + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct packed { logic [31:0] dat; int cyc; } ack_exp_t;
  typedef struct packed { logic we; logic [9:0] addr; logic [127:0] wdata; logic chk; int cyc; } mem_exp_t;
  typedef struct packed { logic [1:0] op; logic [9:0] s0; logic [9:0] s1; logic [9:0] d; int vcyc; } ins_exp_t;

  ack_exp_t ack_q[$];
  mem_exp_t mem_q[$];
  ins_exp_t ins_q[$];

  // Scratchpad model: one-cycle read latency
  logic [127:0] sram [0:1023];
  initial begin
    for (int i = 0; i < 1024; i++) sram[i] = '0;
    sram[1] = 128'h0123_4567_89AB_CDEF_0011_2233_DEAD_BEEF;
    sram[5] = '1;
    mem_rdata_i <= '0;
    forever begin
      @(posedge wb_clk_i);
      if (mem_en_o) begin
        if (mem_we_o) sram[mem_addr_o] = mem_wdata_o;
        else          mem_rdata_i <= sram[mem_addr_o];
      end
    end
  end

  task automatic exp_ack(input logic [31:0] dat, input int cyc);
    ack_exp_t e;
    e.dat = dat; e.cyc = cyc;
    ack_q.push_back(e);
  endtask

  task automatic exp_mem(input logic we, input logic [9:0] addr, input logic [127:0] wdata, input int cyc);
    mem_exp_t e;
    e.we = we; e.addr = addr; e.wdata = wdata; e.chk = we; e.cyc = cyc;
    mem_q.push_back(e);
  endtask

  task automatic exp_ins(input logic [1:0] op, input logic [9:0] s0, input logic [9:0] s1,
                         input logic [9:0] d, input int vcyc);
    ins_exp_t e;
    e.op = op; e.s0 = s0; e.s1 = s1; e.d = d; e.vcyc = vcyc;
    ins_q.push_back(e);
  endtask

  // Monitor: compares everything the DUT presents against the queues
  int vcnt = 0;
  initial begin
    ack_exp_t a;
    mem_exp_t m;
    ins_exp_t n;
    forever begin
      @(negedge wb_clk_i);
      if (wb_rst_i) begin
        checks++;
        if ({wbs_ack_o, wbs_dat_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, instr_valid_o,
             instr_opcode_o, instr_src0_o, instr_src1_o, instr_dst_o} != '0) begin
          failures++;
          $display("FAIL reset_outputs cyc=%0d ack=%0b en=%0b valid=%0b dat=%h required all zero",
                   cnt, wbs_ack_o, mem_en_o, instr_valid_o, wbs_dat_o);
        end
        vcnt = 0;
      end else begin
        if (wbs_ack_o) begin
          checks++;
          if (ack_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_ack cyc=%0d dat=%h required no ack", cnt, wbs_dat_o);
          end else begin
            a = ack_q.pop_front();
            if (a.cyc != cnt || a.dat != wbs_dat_o) begin
              failures++;
              $display("FAIL ack cyc=%0d dat=%h required cyc=%0d dat=%h", cnt, wbs_dat_o, a.cyc, a.dat);
            end
          end
        end
        if (mem_en_o) begin
          checks++;
          if (mem_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_mem cyc=%0d we=%0b addr=%0d", cnt, mem_we_o, mem_addr_o);
          end else begin
            m = mem_q.pop_front();
            if (m.cyc != cnt || m.we != mem_we_o || m.addr != mem_addr_o ||
                (m.chk && m.wdata != mem_wdata_o)) begin
              failures++;
              $display("FAIL mem cyc=%0d we=%0b addr=%0d wdata=%h required cyc=%0d we=%0b addr=%0d wdata=%h",
                       cnt, mem_we_o, mem_addr_o, mem_wdata_o, m.cyc, m.we, m.addr, m.wdata);
            end
          end
        end
        if (instr_valid_o) begin
          checks++;
          if (ins_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_instr cyc=%0d", cnt);
          end else begin
            n = ins_q[0];
            vcnt++;
            if (n.op != instr_opcode_o || n.s0 != instr_src0_o || n.s1 != instr_src1_o || n.d != instr_dst_o) begin
              failures++;
              $display("FAIL instr_fields cyc=%0d op=%0d s0=%0d s1=%0d d=%0d required op=%0d s0=%0d s1=%0d d=%0d",
                       cnt, instr_opcode_o, instr_src0_o, instr_src1_o, instr_dst_o, n.op, n.s0, n.s1, n.d);
            end
            if (instr_ready_i) begin
              checks++;
              if (vcnt != n.vcyc) begin
                failures++;
                $display("FAIL instr_valid_cycles got=%0d required=%0d", vcnt, n.vcyc);
              end
              void'(ins_q.pop_front());
              vcnt = 0;
            end
          end
        end
      end
    end
  end

  // Single Wishbone transfer; returns one cycle into the ack with the strobe released
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    logic got;
    got = 1'b0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_sel_i = sel;  wbs_dat_i = dat;
    for (int i = 0; i < 100; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) begin got = 1'b1; break; end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL xfer_timeout adr=%h got no ack required ack", adr);
    end
  endtask

  int c;
  initial begin
    wb_rst_i = 1'b1; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = '0;  wbs_dat_i = '0;   wbs_adr_i = '0;
    core_busy_i = 1'b0; instr_ready_i = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;

    // Full-sel write then read back
    @(posedge wb_clk_i); #1; c = cnt;
    exp_mem(1'b1, 10'd0, 128'd10, c + 1); exp_ack(32'd0, c + 1);
    wb_xfer(1'b1, 32'd0, 4'hF, 32'd10);
    @(posedge wb_clk_i); #1; c = cnt;
    exp_mem(1'b0, 10'd0, '0, c + 1); exp_ack(32'd10, c + 3);
    wb_xfer(1'b0, 32'd0, 4'hF, 32'd0);

    // Partial-sel read-modify-write on an all-ones word
    @(posedge wb_clk_i); #1; c = cnt;
    exp_mem(1'b0, 10'd5, '0, c + 1);
    exp_mem(1'b1, 10'd5, {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'hFFFF_FF12}, c + 3);
    exp_ack(32'd0, c + 4);
    wb_xfer(1'b1, 32'd5, 4'b0001, 32'h0000_0012);
    @(posedge wb_clk_i); #1; c = cnt;
    exp_mem(1'b0, 10'd5, '0, c + 1);
    exp_mem(1'b1, 10'd5, {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'hAAFF_CC12}, c + 3);
    exp_ack(32'd0, c + 4);
    wb_xfer(1'b1, 32'd5, 4'b1010, 32'hAABB_CCDD);
    @(posedge wb_clk_i); #1; c = cnt;
    exp_mem(1'b0, 10'd5, '0, c + 1); exp_ack(32'hAAFF_CC12, c + 3);
    wb_xfer(1'b0, 32'd5, 4'hF, 32'd0);

    // Instruction issue with ready held low for 4 cycles
    @(posedge wb_clk_i); #1; c = cnt;
    exp_ins(2'd0, 10'd0, 10'd100, 10'd50, 5); exp_ack(32'd0, c + 6);
    fork
      wb_xfer(1'b1, DEF_OPCODE_ADDR, 4'hF, 32'h0C86_4000);
      begin
        repeat (5) @(posedge wb_clk_i);
        #1 instr_ready_i = 1'b1;
        @(posedge wb_clk_i);
        #1 instr_ready_i = 1'b0;
      end
    join

    // Instruction with ready already high: single-cycle handshake
    @(posedge wb_clk_i); #1; c = cnt;
    instr_ready_i = 1'b1;
    exp_ins(2'd3, 10'd1023, 10'd1, 10'd512, 1); exp_ack(32'd0, c + 2);
    wb_xfer(1'b1, DEF_OPCODE_ADDR, 4'hF, 32'h8000_1FFF);
    instr_ready_i = 1'b0;

    // Opcode-register read returns zero
    @(posedge wb_clk_i); #1; c = cnt;
    exp_ack(32'd0, c + 1);
    wb_xfer(1'b0, DEF_OPCODE_ADDR, 4'hF, 32'd0);

    // Memory read stalled by core_busy_i for 10 cycles
    @(posedge wb_clk_i); #1; c = cnt;
    core_busy_i = 1'b1;
    exp_mem(1'b0, 10'd1, '0, c + 11); exp_ack(32'hDEAD_BEEF, c + 13);
    fork
      wb_xfer(1'b0, 32'd1, 4'hF, 32'd0);
      begin
        repeat (10) @(posedge wb_clk_i);
        #1 core_busy_i = 1'b0;
      end
    join

    // Status read while busy, status write ignored, unmapped accesses
    @(posedge wb_clk_i); #1; c = cnt;
    core_busy_i = 1'b1;
    exp_ack(32'd1, c + 1);
    wb_xfer(1'b0, DEF_STATUS_ADDR, 4'hF, 32'd0);
    core_busy_i = 1'b0;
    @(posedge wb_clk_i); #1; c = cnt;
    exp_ack(32'd0, c + 1);
    wb_xfer(1'b1, DEF_STATUS_ADDR, 4'hF, 32'hFFFF_FFFF);
    @(posedge wb_clk_i); #1; c = cnt;
    exp_ack(32'd0, c + 1);
    wb_xfer(1'b0, 32'h0000_0400, 4'hF, 32'd0);
    @(posedge wb_clk_i); #1; c = cnt;
    exp_ack(32'd0, c + 1);
    wb_xfer(1'b1, 32'h3000_0008, 4'hF, 32'h1234_5678);

    // Reset during RD_WAIT drops the read; a later read completes normally
    @(posedge wb_clk_i); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'd0; wbs_sel_i = 4'hF;
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    repeat (2) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    @(posedge wb_clk_i); #1; c = cnt;
    exp_mem(1'b0, 10'd0, '0, c + 1); exp_ack(32'd10, c + 3);
    wb_xfer(1'b0, 32'd0, 4'hF, 32'd0);

    repeat (5) @(posedge wb_clk_i);
    checks++;
    if (ack_q.size() != 0 || mem_q.size() != 0 || ins_q.size() != 0) begin
      failures++;
      $display("FAIL pending_expectations ack=%0d mem=%0d instr=%0d required 0 0 0",
               ack_q.size(), mem_q.size(), ins_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
